// File: rtl/uart_regs_pkg.sv
// Register map, field positions and transmitter state encoding shared by the
// UART transmitter slave and its sub-blocks.
package uart_regs_pkg;

  localparam int unsigned ADDR_CTRL   = 3;
  localparam int unsigned ADDR_BAUD   = 4;
  localparam int unsigned ADDR_STATUS = 5;
  localparam int unsigned ADDR_TXBUF  = 7;

  localparam int unsigned CTRL_START_BIT     = 7;
  localparam int unsigned STATUS_TX_DONE_BIT = 5;
  localparam int unsigned STATUS_BUSY_BIT    = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_baud_nco.sv
// Phase-accumulator baud generator: one tick per carry out of the 32-bit
// accumulator, so the bit period is 2^32 / increment clocks on average.
module uart_baud_nco (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        clr_i,
  input  logic [31:0] inc_i,
  output logic        tick_o
);

  logic [31:0] acc_q;
  logic [31:0] acc_d;
  logic [32:0] sum;

  assign sum    = {1'b0, acc_q} + {1'b0, inc_i};
  assign tick_o = en_i & sum[32];

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = sum[31:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/uart_tx_wb_slave.sv
// Wishbone-style slave UART transmitter: register file, bus handshake and the
// 8N1 framing state machine, with the baud tick supplied by uart_baud_nco.
module uart_tx_wb_slave
  import uart_regs_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int ADDR_LSBS = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic        stb_i,
  input  logic        cyc_i,
  output logic        ack_o,
  output logic        err_o,
  output logic        tx_o,
  output logic        irq_o
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic [ADDR_LSBS-1:0] regAddr;
  logic                 hitCtrl;
  logic                 hitBaud;
  logic                 hitStatus;
  logic                 hitTxbuf;
  logic                 mapped;
  logic                 wrAccess;
  logic                 startReq;
  logic                 startAccept;
  logic                 statusWr;
  logic                 tick;
  logic                 unusedBits;

  logic [31:0] baud_q;
  logic [7:0]  txBuf_q;
  logic [7:0]  shift_q;
  logic [2:0]  bitCnt_q;
  logic        busy_q;
  logic        txDone_q;
  logic        tx_q;
  logic        ack_q;
  logic        err_q;
  tx_state_e   state_q;

  // The master never drives cyc_i, and only the low address bits are decoded.
  assign unusedBits = ^{cyc_i, addr_i[31:ADDR_LSBS]};

  assign regAddr   = addr_i[ADDR_LSBS-1:0];
  assign hitCtrl   = (regAddr == ADDR_LSBS'(ADDR_CTRL));
  assign hitBaud   = (regAddr == ADDR_LSBS'(ADDR_BAUD));
  assign hitStatus = (regAddr == ADDR_LSBS'(ADDR_STATUS));
  assign hitTxbuf  = (regAddr == ADDR_LSBS'(ADDR_TXBUF));
  assign mapped    = hitCtrl | hitBaud | hitStatus | hitTxbuf;

  assign wrAccess    = stb_i & we_i;
  assign startReq    = wrAccess & hitCtrl & sel_i[0] & dat_i[CTRL_START_BIT];
  assign startAccept = startReq & ~busy_q;
  assign statusWr    = wrAccess & hitStatus;

  uart_baud_nco uBaudNco (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (busy_q),
    .clr_i  (startAccept),
    .inc_i  (baud_q),
    .tick_o (tick)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      baud_q  <= '0;
      txBuf_q <= '0;
    end else begin
      if (wrAccess & hitBaud) begin
        for (int i = 0; i < 4; i++) begin
          if (sel_i[i]) begin
            baud_q[8*i +: 8] <= dat_i[8*i +: 8];
          end
        end
      end
      if (wrAccess & hitTxbuf & sel_i[0]) begin
        txBuf_q <= dat_i[7:0];
      end
    end
  end

  // Ack/err follow the strobe by one clock and stay up while it is held.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ack_q <= stb_i & mapped;
      err_q <= stb_i & ~mapped;
    end
  end

  // The done-set assignments come after the status-write clear so a
  // coincident completion wins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      bitCnt_q <= '0;
      busy_q   <= 1'b0;
      txDone_q <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      if (statusWr) begin
        txDone_q <= 1'b0;
      end
      unique case (state_q)
        ST_IDLE: begin
          tx_q <= 1'b1;
          if (startAccept) begin
            shift_q  <= txBuf_q;
            busy_q   <= 1'b1;
            txDone_q <= 1'b0;
            tx_q     <= 1'b0;
            state_q  <= ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            tx_q     <= shift_q[0];
            shift_q  <= {1'b0, shift_q[7:1]};
            bitCnt_q <= '0;
            state_q  <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bitCnt_q == LAST_BIT) begin
              tx_q    <= 1'b1;
              state_q <= ST_STOP;
            end else begin
              tx_q     <= shift_q[0];
              shift_q  <= {1'b0, shift_q[7:1]};
              bitCnt_q <= bitCnt_q + 3'd1;
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            busy_q   <= 1'b0;
            txDone_q <= 1'b1;
            state_q  <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    dat_o = '0;
    if (stb_i & ~we_i) begin
      if (hitBaud) begin
        dat_o = baud_q;
      end else if (hitStatus) begin
        dat_o[STATUS_TX_DONE_BIT] = txDone_q;
        dat_o[STATUS_BUSY_BIT]    = busy_q;
      end else if (hitTxbuf) begin
        dat_o = {24'h0, txBuf_q};
      end
    end
  end

  assign ack_o = ack_q;
  assign err_o = err_q;
  assign tx_o  = tx_q;
  assign irq_o = txDone_q;

endmodule
